// File: rtl/ult_trigger.sv
// ult_trigger: transmit-side sequencer for the ultrasonic ranging peripheral.
// Fires a fixed-width TRIG pulse, opens a measurement window while the
// synchronized echo is high, flags done/timeout, and enforces a hold-off
// before the sensor may be triggered again. All outputs are registered.
module ult_trigger #(
  parameter int TRIG_CYC      = 500,
  parameter int ECHO_WAIT_CYC = 25000,
  parameter int ECHO_MAX_CYC  = 1250000,
  parameter int HOLDOFF_CYC   = 3000000,
  parameter int CNT_W         = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic continuous,
  input  logic echo,
  output logic trig,
  output logic meas_en,
  output logic busy,
  output logic done,
  output logic timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_HI,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  // Terminal counts: each state leaves on its last cycle, so the shared
  // counter never wraps.
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ECHO_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_MAX_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             echo_meta_reg;
  logic             echo_s_reg;
  logic             trig_reg;
  logic             meas_en_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             timeout_reg;

  assign trig    = trig_reg;
  assign meas_en = meas_en_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign timeout = timeout_reg;

  // Two-flop synchronizer for the asynchronous echo line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_meta_reg <= 1'b0;
      echo_s_reg    <= 1'b0;
    end else begin
      echo_meta_reg <= echo;
      echo_s_reg    <= echo_meta_reg;
    end
  end

  // Ranging-cycle FSM with shared counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      trig_reg    <= 1'b0;
      meas_en_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      cnt_reg     <= cnt_reg + CNT_W'(1);
      case (state_reg)
        S_IDLE: begin
          // Counter parked at zero while idle; start while busy is never seen here.
          cnt_reg <= '0;
          if (start || continuous) begin
            state_reg <= S_TRIG;
            trig_reg  <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        S_TRIG: begin
          if (cnt_reg == TRIG_LAST) begin
            state_reg <= S_WAIT_HI;
            cnt_reg   <= '0;
            trig_reg  <= 1'b0;
          end
        end
        S_WAIT_HI: begin
          // An echo seen on the final wait cycle still counts as an echo.
          if (echo_s_reg) begin
            state_reg   <= S_ECHO;
            cnt_reg     <= '0;
            meas_en_reg <= 1'b1;
          end else if (cnt_reg == WAIT_LAST) begin
            state_reg   <= S_HOLDOFF;
            cnt_reg     <= '0;
            timeout_reg <= 1'b1;
          end
        end
        S_ECHO: begin
          // Echo fall takes priority over the max-duration limit.
          if (!echo_s_reg) begin
            state_reg   <= S_HOLDOFF;
            cnt_reg     <= '0;
            meas_en_reg <= 1'b0;
            done_reg    <= 1'b1;
          end else if (cnt_reg == ECHO_LAST) begin
            state_reg   <= S_HOLDOFF;
            cnt_reg     <= '0;
            meas_en_reg <= 1'b0;
            timeout_reg <= 1'b1;
          end
        end
        S_HOLDOFF: begin
          // Echo is deliberately ignored, so a stuck-high line cannot hold us here.
          if (cnt_reg == HOLD_LAST) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg   <= S_IDLE;
          cnt_reg     <= '0;
          trig_reg    <= 1'b0;
          meas_en_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ult_trigger.sv
// Testbench for ult_trigger: an echo driver reacts to each trigger with a
// planned or random echo and pushes the predicted outcome; a monitor pops
// and compares at every done/timeout pulse.
module tb_ult_trigger;

  localparam int TRIG_CYC      = 4;
  localparam int ECHO_WAIT_CYC = 20;
  localparam int ECHO_MAX_CYC  = 100;
  localparam int HOLDOFF_CYC   = 10;
  localparam int CNT_W         = 22;
  // Cycles from an echo edge (driven just after a clk edge) to meas_en reacting.
  localparam int SYNC_LAT      = 3;

  logic clk = 1'b0;
  logic rst, start, continuous, echo;
  logic trig, meas_en, busy, done, timeout;
  bit   rel_go = 1'b0;

  typedef struct {
    bit is_done;
    int offset;
    int meas_len;
  } exp_t;

  typedef struct {
    int d;
    int len;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int checks = 0;
  int errors = 0;
  int trig_rises = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  ult_trigger #(
    .TRIG_CYC(TRIG_CYC),
    .ECHO_WAIT_CYC(ECHO_WAIT_CYC),
    .ECHO_MAX_CYC(ECHO_MAX_CYC),
    .HOLDOFF_CYC(HOLDOFF_CYC),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .continuous(continuous),
    .echo(echo),
    .trig(trig),
    .meas_en(meas_en),
    .busy(busy),
    .done(done),
    .timeout(timeout)
  );

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Outcome of one ranging cycle given echo delay d after trig falls (-1 = none)
  // and echo length len.
  function automatic exp_t predict(input int d, input int len);
    exp_t e;
    if (d >= 0 && d + SYNC_LAT <= ECHO_WAIT_CYC) begin
      e.offset = d + SYNC_LAT;
      if (len <= ECHO_MAX_CYC) begin
        e.is_done  = 1'b1;
        e.meas_len = len;
      end else begin
        e.is_done  = 1'b0;
        e.meas_len = ECHO_MAX_CYC;
      end
    end else begin
      e.is_done  = 1'b0;
      e.offset   = ECHO_WAIT_CYC;
      e.meas_len = 0;
    end
    return e;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    int k;
    k = int'($urandom_range(0, 9));
    if (k == 0) begin
      p.d = -1; p.len = 0;
    end else if (k == 1) begin
      p.d = int'($urandom_range(18, 19)); p.len = 3;
    end else begin
      p.d = int'($urandom_range(0, 17)); p.len = int'($urandom_range(1, 105));
    end
    return p;
  endfunction

  // Echo driver: on each trigger fall, play one echo and predict the result.
  initial begin : echo_driver
    logic  prev;
    plan_t p;
    prev = 1'b0;
    echo = 1'b1;
    wait (rel_go);
    echo = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && prev && !trig) begin
        if (plan_q.size() > 0) p = plan_q.pop_front();
        else p = rand_plan();
        exp_q.push_back(predict(p.d, p.len));
        if (p.d >= 0) begin
          if (p.d > 0) begin
            repeat (p.d) @(posedge clk);
            #1;
          end
          echo = 1'b1;
          repeat (p.len) @(posedge clk);
          #1;
          echo = 1'b0;
        end
      end
      prev = trig & rst;
    end
  end

  // Monitor: measures each cycle and checks it against the scoreboard.
  initial begin : monitor
    logic trig_prev;
    int   trig_w, since, meas_cnt, got_off, ho_cnt, txn;
    bit   armed, in_ho;
    exp_t e;
    trig_prev = 1'b0; trig_w = 0; since = 0; meas_cnt = 0; got_off = -1;
    ho_cnt = 0; armed = 1'b0; in_ho = 1'b0; txn = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        trig_prev = 1'b0; trig_w = 0; since = 0; meas_cnt = 0; got_off = -1;
        ho_cnt = 0; armed = 1'b0; in_ho = 1'b0;
      end else begin
        if (trig && !trig_prev) trig_rises++;
        if (trig) trig_w++;
        if (!trig && trig_prev) begin
          chk("trig_width", trig_w, TRIG_CYC);
          trig_w = 0; since = 0; armed = 1'b1; got_off = -1; meas_cnt = 0;
        end else if (armed) begin
          since++;
        end
        if (meas_en) begin
          meas_cnt++;
          if (got_off < 0) got_off = since;
        end
        if (done || timeout) begin
          pulses++;
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", int'({done, timeout}), 0);
          end else begin
            e = exp_q.pop_front();
            if (got_off < 0) got_off = since;
            txn++;
            $display("txn %0d: %s offset=%0d meas=%0d (want %s offset=%0d meas=%0d)",
                     txn, done ? "done" : "timeout", got_off, meas_cnt,
                     e.is_done ? "done" : "timeout", e.offset, e.meas_len);
            chk("result_kind", int'({done, timeout}), e.is_done ? 2 : 1);
            chk("window_offset", got_off, e.offset);
            chk("meas_len", meas_cnt, e.meas_len);
          end
          armed = 1'b0; in_ho = 1'b1; ho_cnt = 0;
        end
        if (in_ho) begin
          if (busy) ho_cnt++;
          else begin
            chk("holdoff_len", ho_cnt, HOLDOFF_CYC);
            in_ho = 1'b0;
          end
        end
        trig_prev = trig;
      end
    end
  end

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_reached_idle"}, int'(busy), 0);
  endtask

  task automatic run_one(input string name, input int d, input int len);
    int base;
    plan_t p;
    base = trig_rises;
    p.d = d; p.len = len;
    plan_q.push_back(p);
    do_start();
    wait_idle(name);
    chk({name, "_trig_count"}, trig_rises - base, 1);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, base_p, hi, n;
    rst = 1'b0; start = 1'b1; continuous = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({trig, meas_en, busy, done, timeout}), 0);
    start = 1'b0;
    rel_go = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (trig || busy || done || timeout) hi++;
    end
    chk("post_reset_quiet", hi, 0);

    // Directed cycles, including both window boundaries.
    run_one("normal", 5, 30);
    run_one("no_echo", -1, 0);
    run_one("stuck", 3, 200);
    chk("stuck_idle_despite_echo", int'({busy, echo}), 1);
    n = 0;
    while (echo && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    run_one("last_wait_cycle_echo_at_limit", 17, 100);
    run_one("late_echo", 18, 5);
    run_one("echo_over_limit", 17, 101);

    // Extra starts while busy must not spawn another cycle.
    base = trig_rises;
    begin
      plan_t p;
      p.d = 2; p.len = 10;
      plan_q.push_back(p);
    end
    do_start();
    repeat (3) begin
      repeat (7) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle("ignored_start");
    chk("ignored_start_trig_count", trig_rises - base, 1);

    // Continuous mode with random echoes.
    continuous = 1'b1;
    base_p = pulses;
    n = 0;
    while (pulses < base_p + 25 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("continuous_cycles", int'(pulses >= base_p + 25), 1);
    continuous = 1'b0;
    wait_idle("continuous_stop");
    base = trig_rises;
    repeat (40) @(negedge clk);
    chk("continuous_stays_idle", trig_rises - base, 0);

    // Reset in the middle of an echo window.
    begin
      plan_t p;
      p.d = 2; p.len = 50;
      plan_q.push_back(p);
    end
    do_start();
    n = 0;
    while (!meas_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_window_open", int'(meas_en), 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("midrst_async_drop", int'({trig, meas_en, busy, done, timeout}), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    base_p = pulses;
    repeat (60) @(negedge clk);
    chk("midrst_no_pulse", pulses - base_p, 0);
    chk("midrst_idle", int'(busy), 0);

    run_one("recover", 1, 7);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
